// File: rtl/sha3_pkg.sv
// Shared constants and FSM state encoding for the streaming SHA-3/Keccak padder.
package sha3_pkg;

  localparam logic [7:0] DS_SHA3   = 8'h06;
  localparam logic [7:0] DS_SHAKE  = 8'h1F;
  localparam logic [7:0] DS_KECCAK = 8'h01;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ZFILL  = 2'd1,
    FULL   = 2'd2
  } state_e;

endpackage

// File: rtl/sha3_pad_word.sv
// Single-word padder: keeps the first byte_num bytes, inserts the domain-separation
// byte right after them and clears the remaining bytes.
module sha3_pad_word
  import sha3_pkg::*;
#(
  parameter int         W       = 32,
  parameter logic [7:0] DS_BYTE = DS_SHA3,
  localparam int        NB      = W / 8,
  localparam int        BNW     = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [W-1:0]   word,
  input  logic [BNW-1:0] byte_num,
  output logic [W-1:0]   padded
);

  int bn_s;

  // Byte mask plus suffix insertion; an out-of-range byte_num is clamped to NB-1.
  always_comb begin
    bn_s   = (int'(byte_num) >= NB) ? (NB - 1) : int'(byte_num);
    padded = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < bn_s) begin
        padded[W-1-8*i -: 8] = word[W-1-8*i -: 8];
      end else if (i == bn_s) begin
        padded[W-1-8*i -: 8] = DS_BYTE;
      end else begin
        padded[W-1-8*i -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha3_padder_stream.sv
// Streaming SHA-3/Keccak padder: shifts W-bit words into a rate-sized block, applies
// the suffix and pad10*1 rule, and holds each complete block until the consumer acks it.
module sha3_padder_stream
  import sha3_pkg::*;
#(
  parameter int         W         = 32,
  parameter int         RATE_BITS = 1088,
  parameter logic [7:0] DS_BYTE   = DS_SHA3,
  localparam int        NB        = W / 8,
  localparam int        WORDS     = RATE_BITS / W,
  localparam int        BNW       = (NB > 1) ? $clog2(NB) : 1,
  localparam int        CW        = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W-1:0]         in,
  input  logic                 in_valid,
  input  logic                 is_last,
  input  logic [BNW-1:0]       byte_num,
  output logic                 in_ready,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ack
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(WORDS - 1);

  state_e               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [RATE_BITS-1:0] buf_r, buf_s;
  logic                 out_valid_r, out_valid_s;
  logic                 out_last_r, out_last_s;
  logic [W-1:0]         padded_s;

  sha3_pad_word #(
    .W       (W),
    .DS_BYTE (DS_BYTE)
  ) u_pad_word (
    .word     (in),
    .byte_num (byte_num),
    .padded   (padded_s)
  );

  // Next-state, counter and buffer update for ACCEPT / ZFILL / FULL.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    buf_s       = buf_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    case (state_r)
      ACCEPT: begin
        if (in_valid) begin
          cnt_s = cnt_r + CW'(1'b1);
          if (!is_last) begin
            buf_s = {buf_r[RATE_BITS-W-1:0], in};
            if (cnt_r == LAST_SLOT) begin
              state_s     = FULL;
              out_valid_s = 1'b1;
              out_last_s  = 1'b0;
            end else begin
              state_s = ACCEPT;
            end
          end else if (cnt_r == LAST_SLOT) begin
            // Suffix and final pad bit share the block's last word (0x86 for SHA3).
            buf_s       = {buf_r[RATE_BITS-W-1:0], padded_s | W'(PAD_END)};
            state_s     = FULL;
            out_valid_s = 1'b1;
            out_last_s  = 1'b1;
          end else begin
            buf_s   = {buf_r[RATE_BITS-W-1:0], padded_s};
            state_s = ZFILL;
          end
        end else begin
          state_s = ACCEPT;
        end
      end
      ZFILL: begin
        cnt_s = cnt_r + CW'(1'b1);
        if (cnt_r == LAST_SLOT) begin
          buf_s       = {buf_r[RATE_BITS-W-1:0], W'(PAD_END)};
          state_s     = FULL;
          out_valid_s = 1'b1;
          out_last_s  = 1'b1;
        end else begin
          buf_s   = {buf_r[RATE_BITS-W-1:0], {W{1'b0}}};
          state_s = ZFILL;
        end
      end
      FULL: begin
        if (out_ack) begin
          state_s     = ACCEPT;
          cnt_s       = '0;
          buf_s       = '0;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s     = ACCEPT;
        cnt_s       = '0;
        buf_s       = '0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ACCEPT;
      cnt_r       <= '0;
      buf_r       <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      buf_r       <= buf_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
    end
  end

  assign in_ready  = reset_n & (state_r == ACCEPT);
  assign out       = buf_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_sha3_padder_stream.sv
// Randomised bench for sha3_padder_stream, checked against a byte-level
// suffix + pad10*1 reference model of the padded message.
module tb_sha3_padder_stream;

  localparam int W       = 32;
  localparam int RB      = 1088;
  localparam int RB2     = 1344;
  localparam int WORDS   = RB / W;
  localparam int WORDS2  = RB2 / W;
  localparam int RBYTES  = RB / 8;
  localparam int RBYTES2 = RB2 / 8;

  logic          clk = 1'b0;
  logic          reset_n_s;
  logic [W-1:0]  in_s, in2_s;
  logic          in_valid_s, is_last_s, in_ready_s;
  logic          in2_valid_s, is_last2_s, in2_ready_s;
  logic [1:0]    byte_num_s, byte_num2_s;
  logic [RB-1:0] out_s;
  logic [RB2-1:0] out2_s;
  logic          out_valid_s, out_last_s, out_ack_s;
  logic          out2_valid_s, out2_last_s, out2_ack_s;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            t_last = -1;
  logic [7:0]    msg_q [$];
  logic [RB-1:0] last_blk_r;

  sha3_padder_stream #(.W(W), .RATE_BITS(RB), .DS_BYTE(8'h06)) dut (
    .clk(clk), .reset_n(reset_n_s), .in(in_s), .in_valid(in_valid_s), .is_last(is_last_s),
    .byte_num(byte_num_s), .in_ready(in_ready_s), .out(out_s), .out_valid(out_valid_s),
    .out_last(out_last_s), .out_ack(out_ack_s)
  );

  sha3_padder_stream #(.W(W), .RATE_BITS(RB2), .DS_BYTE(8'h1F)) dut2 (
    .clk(clk), .reset_n(reset_n_s), .in(in2_s), .in_valid(in2_valid_s), .is_last(is_last2_s),
    .byte_num(byte_num2_s), .in_ready(in2_ready_s), .out(out2_s), .out_valid(out2_valid_s),
    .out_last(out2_last_s), .out_ack(out2_ack_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Padded message = msg || ds || 0* with 0x80 ORed into the last byte of a whole number of blocks.
  function automatic logic [7:0] pad_byte(int g, int len, logic [7:0] ds, int rbytes);
    int plen;
    logic [7:0] b;
    plen = (len / rbytes + 1) * rbytes;
    b = (g < len) ? msg_q[g] : 8'h00;
    if (g == len) b = b | ds;
    if (g == plen - 1) b = b | 8'h80;
    return b;
  endfunction

  function automatic logic [31:0] exp_word(int blk, int w, int len, logic [7:0] ds, int rbytes);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[31-8*b -: 8] = pad_byte(blk * rbytes + w * 4 + b, len, ds, rbytes);
    return r;
  endfunction

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic drive_msg(input int len, input int idle_pct);
    int nwords, i, guard, idx;
    logic [31:0] wd;
    nwords = len / 4 + 1;
    i = 0;
    guard = 0;
    while (i < nwords && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (in_ready_s && $urandom_range(99) < idle_pct) begin
        in_valid_s = 1'b0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          idx = i * 4 + b;
          wd[31-8*b -: 8] = (idx < len) ? msg_q[idx] : 8'(i * 37 + b * 11 + len + 1);
        end
        in_s       = wd;
        in_valid_s = 1'b1;
        is_last_s  = (i == nwords - 1);
        byte_num_s = is_last_s ? 2'(len % 4) : 2'(i);
        if (in_ready_s) begin
          if (is_last_s) t_last = cyc;
          i++;
        end
      end
    end
    if (i < nwords) check("drv_timeout", 64'(i), 64'(nwords));
    @(negedge clk);
    in_valid_s = 1'b0;
    is_last_s  = 1'b0;
  endtask

  task automatic consume_msg(input int len, input int ack_min, input int ack_max);
    int nblk, k, wt, d;
    logic [RB-1:0] snap;
    nblk = len / RBYTES + 1;
    k = (len / 4) % WORDS;
    for (int b = 0; b < nblk; b++) begin
      wt = 0;
      @(negedge clk);
      while (!out_valid_s && wt < 400) begin
        @(negedge clk);
        wt++;
      end
      if (!out_valid_s) begin
        check("blk_timeout", 64'(b), 64'(nblk));
        return;
      end
      if (b == nblk - 1) check("latency", 64'(cyc - t_last), 64'(WORDS - k));
      for (int w = 0; w < WORDS; w++)
        check("blk_word", {32'(w), out_s[RB-1-32*w -: 32]}, {32'(w), exp_word(b, w, len, 8'h06, RBYTES)});
      check("out_last", 64'(out_last_s), 64'(b == nblk - 1));
      snap = out_s;
      last_blk_r = out_s;
      d = $urandom_range(ack_max, ack_min);
      repeat (d) begin
        @(negedge clk);
        check("stall_ready", 64'(in_ready_s), 64'd0);
        check("stall_hold", 64'(out_s === snap), 64'd1);
      end
      out_ack_s = 1'b1;
      @(negedge clk);
      out_ack_s = 1'b0;
      check("ack_valid", 64'(out_valid_s), 64'd0);
      check("ack_ready", 64'(in_ready_s), 64'd1);
    end
  endtask

  task automatic run_msg(input int idle_pct, input int ack_min, input int ack_max);
    int len;
    len = msg_q.size();
    t_last = -1;
    fork
      drive_msg(len, idle_pct);
      consume_msg(len, ack_min, ack_max);
    join
  endtask

  task automatic check_empty_blk(input string tag);
    check({tag, "_w0"}, 64'(last_blk_r[RB-1 -: 32]), 64'h06000000);
    check({tag, "_wl"}, 64'(last_blk_r[31:0]), 64'h00000080);
  endtask

  initial begin
    int wt, t0;
    reset_n_s = 1'b0;
    in_s = '0; in_valid_s = 1'b0; is_last_s = 1'b0; byte_num_s = 2'd0; out_ack_s = 1'b0;
    in2_s = '0; in2_valid_s = 1'b0; is_last2_s = 1'b0; byte_num2_s = 2'd0; out2_ack_s = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid_s), 64'd0);
    check("rst_last", 64'(out_last_s), 64'd0);
    check("rst_ready", 64'(in_ready_s), 64'd0);
    check("rst_out", 64'(out_s != '0), 64'd0);
    reset_n_s = 1'b1;
    #1 check("rel_ready", 64'(in_ready_s), 64'd1);

    msg_q.delete();
    run_msg(0, 0, 0);
    check_empty_blk("empty");

    msg_q = '{8'h11, 8'h22, 8'h33};
    run_msg(0, 0, 1);
    check("one_word_bn3", 64'(last_blk_r[RB-1 -: 32]), 64'h11223306);
    msg_q = '{8'h11};
    run_msg(0, 0, 1);
    check("one_word_bn1", 64'(last_blk_r[RB-1 -: 32]), 64'h11060000);

    rand_msg(RBYTES);
    run_msg(0, 0, 2);
    check_empty_blk("exact_rate");

    rand_msg(RBYTES - 4);
    msg_q.push_back(8'h11); msg_q.push_back(8'h22); msg_q.push_back(8'h33);
    run_msg(0, 0, 1);
    check("last_slot_86", 64'(last_blk_r[31:0]), 64'h11223386);

    rand_msg(200);
    run_msg(0, 5, 5);

    for (int m = 0; m < 8; m++) begin
      rand_msg($urandom_range(400));
      run_msg(20, 0, 4);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_s = $urandom; in_valid_s = 1'b1; is_last_s = 1'b0;
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    reset_n_s = 1'b0;
    #1 check("rst_mid_ready", 64'(in_ready_s), 64'd0);
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid_s), 64'd0);
    check("rst_mid_buf", 64'(out_s != '0), 64'd0);
    reset_n_s = 1'b1;
    msg_q.delete();
    run_msg(0, 0, 0);
    check_empty_blk("after_rst_acc");

    @(negedge clk);
    in_s = $urandom; in_valid_s = 1'b1; is_last_s = 1'b1; byte_num_s = 2'd0;
    @(negedge clk);
    in_valid_s = 1'b0; is_last_s = 1'b0;
    repeat (5) @(negedge clk);
    check("zf_ready", 64'(in_ready_s), 64'd0);
    reset_n_s = 1'b0;
    @(negedge clk);
    check("zf_rst_valid", 64'(out_valid_s), 64'd0);
    check("zf_rst_buf", 64'(out_s != '0), 64'd0);
    reset_n_s = 1'b1;
    run_msg(0, 0, 0);
    check_empty_blk("after_rst_zf");

    // SHAKE128 instance: empty message
    msg_q.delete();
    @(negedge clk);
    check("s2_ready", 64'(in2_ready_s), 64'd1);
    in2_s = $urandom; in2_valid_s = 1'b1; is_last2_s = 1'b1; byte_num2_s = 2'd0;
    t0 = cyc;
    @(negedge clk);
    in2_valid_s = 1'b0; is_last2_s = 1'b0;
    wt = 0;
    while (!out2_valid_s && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    check("s2_valid", 64'(out2_valid_s), 64'd1);
    check("s2_latency", 64'(cyc - t0), 64'(WORDS2));
    for (int w = 0; w < WORDS2; w++)
      check("s2_word", {32'(w), out2_s[RB2-1-32*w -: 32]}, {32'(w), exp_word(0, w, 0, 8'h1F, RBYTES2)});
    check("s2_w0", 64'(out2_s[RB2-1 -: 32]), 64'h1F000000);
    check("s2_w41", 64'(out2_s[31:0]), 64'h00000080);
    check("s2_last", 64'(out2_last_s), 64'd1);
    out2_ack_s = 1'b1;
    @(negedge clk);
    out2_ack_s = 1'b0;
    check("s2_ack_valid", 64'(out2_valid_s), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
